// File: rtl/pifo_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pifo_sched_pkg
//  Purpose  : Shared types and constants for the PIFO scheduler front-end.
//  Revision : 1.0 - initial release
// ============================================================================
package pifo_sched_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE1 = 2'd1,
        SETTLE2 = 2'd2
    } state_t;

    // Cycles spent after each PIFO operation before the head is trustworthy
    localparam int SETTLE_CYCLES = 2;

    localparam int DEF_NUM_PORTS    = 4;
    localparam int DEF_L2_NUM_PORTS = 2;
    localparam int DEF_L2_MAX_SIZE  = 3;
    localparam int DEF_RANK_WIDTH   = 8;
    localparam int DEF_META_WIDTH   = 8;

endpackage
`default_nettype wire

// File: rtl/pifo_sched_ctrl_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arbiter
//  Purpose  : Combinational round-robin pick of the first requester at or
//             above ptr, wrapping around.
//  Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import pifo_sched_pkg::*;
#(
    parameter int NUM_PORTS    = DEF_NUM_PORTS,
    parameter int L2_NUM_PORTS = DEF_L2_NUM_PORTS
) (
    input  logic [NUM_PORTS-1:0]    req,
    input  logic [L2_NUM_PORTS-1:0] ptr,
    output logic [NUM_PORTS-1:0]    grant,
    output logic [L2_NUM_PORTS-1:0] grant_idx,
    output logic                    any_req
);

    int w_idx;

    // Scan from the farthest candidate back to ptr so the last hit wins
    always_comb begin
        w_idx     = 0;
        grant_idx = '0;
        any_req   = 1'b0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            w_idx = (int'(ptr) + i) % NUM_PORTS;
            if (req[w_idx]) begin
                grant_idx = L2_NUM_PORTS'(w_idx);
                any_req   = 1'b1;
            end
        end
        grant = '0;
        if (any_req) begin
            grant[grant_idx] = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pifo_sched_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pifo_sched_ctrl
//  Purpose  : Shares one PIFO between NUM_PORTS round-robin enqueuers and one
//             dequeuer, serialising operations and tracking occupancy.
//  Options  : PIFO_SCHED_CTRL_STATS_EN adds insert/remove/full-stall counters.
//  Revision : 1.0 - initial release
// ============================================================================
module pifo_sched_ctrl
    import pifo_sched_pkg::*;
#(
    parameter int NUM_PORTS    = DEF_NUM_PORTS,
    parameter int L2_NUM_PORTS = DEF_L2_NUM_PORTS,
    parameter int L2_MAX_SIZE  = DEF_L2_MAX_SIZE,
    parameter int MAX_SIZE     = 2 ** L2_MAX_SIZE,
    parameter int RANK_WIDTH   = DEF_RANK_WIDTH,
    parameter int META_WIDTH   = DEF_META_WIDTH
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_PORTS-1:0]             enq_valid,
    output logic [NUM_PORTS-1:0]             enq_ready,
    input  logic [NUM_PORTS*RANK_WIDTH-1:0]  enq_rank,
    input  logic [NUM_PORTS*META_WIDTH-1:0]  enq_meta,
    output logic                             deq_valid,
    input  logic                             deq_ready,
    output logic [RANK_WIDTH-1:0]            deq_rank,
    output logic [META_WIDTH-1:0]            deq_meta,
    output logic [L2_MAX_SIZE:0]             occupancy,
    output logic                             pifo_insert,
    output logic                             pifo_remove,
    output logic [RANK_WIDTH-1:0]            pifo_rank_in,
    output logic [META_WIDTH-1:0]            pifo_meta_in,
    input  logic [RANK_WIDTH-1:0]            pifo_rank_out,
    input  logic [META_WIDTH-1:0]            pifo_meta_out,
    input  logic                             pifo_valid_out
`ifdef PIFO_SCHED_CTRL_STATS_EN
    ,
    output logic [31:0]                      stat_enq_cnt,
    output logic [31:0]                      stat_deq_cnt,
    output logic [31:0]                      stat_full_stall
`endif
);

    localparam logic [L2_MAX_SIZE:0]    c_max_occ   = (L2_MAX_SIZE+1)'(MAX_SIZE);
    localparam logic [L2_NUM_PORTS-1:0] c_last_port = L2_NUM_PORTS'(NUM_PORTS - 1);

    state_t                  r_state;
    logic [L2_MAX_SIZE:0]    r_occ;
    logic [L2_NUM_PORTS-1:0] r_rr_ptr;

    logic [NUM_PORTS-1:0]    w_grant;
    logic [L2_NUM_PORTS-1:0] w_grant_idx;
    logic                    w_any_req;
    logic                    w_idle;
    logic                    w_full;
    logic                    w_deq_valid;
    logic                    w_deq_fire;
    logic                    w_enq_fire;

    rr_arbiter #(
        .NUM_PORTS    (NUM_PORTS),
        .L2_NUM_PORTS (L2_NUM_PORTS)
    ) u_rr_arbiter (
        .req       (enq_valid),
        .ptr       (r_rr_ptr),
        .grant     (w_grant),
        .grant_idx (w_grant_idx),
        .any_req   (w_any_req)
    );

    // Gating with rst keeps every handshake output low while reset is held
    assign w_idle      = (r_state == IDLE) && !rst;
    assign w_full      = (r_occ == c_max_occ);
    assign w_deq_valid = w_idle && (r_occ != '0) && pifo_valid_out;
    assign w_deq_fire  = w_deq_valid && deq_ready;
    assign w_enq_fire  = w_idle && !w_deq_fire && !w_full && w_any_req;

    assign deq_valid    = w_deq_valid;
    assign deq_rank     = pifo_rank_out;
    assign deq_meta     = pifo_meta_out;
    assign occupancy    = r_occ;
    assign enq_ready    = w_enq_fire ? w_grant : '0;
    assign pifo_insert  = w_enq_fire;
    assign pifo_remove  = w_deq_fire;
    assign pifo_rank_in = w_enq_fire ? enq_rank[w_grant_idx*RANK_WIDTH +: RANK_WIDTH] : '0;
    assign pifo_meta_in = w_enq_fire ? enq_meta[w_grant_idx*META_WIDTH +: META_WIDTH] : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_occ    <= '0;
            r_rr_ptr <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_deq_fire) begin
                        r_occ   <= r_occ - 1'b1;
                        r_state <= SETTLE1;
                    end else if (w_enq_fire) begin
                        r_occ    <= r_occ + 1'b1;
                        r_rr_ptr <= (w_grant_idx == c_last_port) ? '0 : w_grant_idx + 1'b1;
                        r_state  <= SETTLE1;
                    end
                end
                SETTLE1: r_state <= SETTLE2;
                SETTLE2: r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef PIFO_SCHED_CTRL_STATS_EN
    logic [31:0] r_stat_enq_cnt;
    logic [31:0] r_stat_deq_cnt;
    logic [31:0] r_stat_full_stall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stat_enq_cnt    <= '0;
            r_stat_deq_cnt    <= '0;
            r_stat_full_stall <= '0;
        end else begin
            if (w_enq_fire) begin
                r_stat_enq_cnt <= r_stat_enq_cnt + 32'd1;
            end
            if (w_deq_fire) begin
                r_stat_deq_cnt <= r_stat_deq_cnt + 32'd1;
            end
            if (w_idle && w_full && (|enq_valid)) begin
                r_stat_full_stall <= r_stat_full_stall + 32'd1;
            end
        end
    end

    assign stat_enq_cnt    = r_stat_enq_cnt;
    assign stat_deq_cnt    = r_stat_deq_cnt;
    assign stat_full_stall = r_stat_full_stall;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pifo_sched_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pifo_sched_ctrl
//  Purpose  : Directed self-checking bench for pifo_sched_ctrl with a small
//             behavioural PIFO attached.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pifo_sched_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  enq_valid = '0;
    logic [3:0]  enq_ready;
    logic [31:0] enq_rank = '0;
    logic [31:0] enq_meta = '0;
    logic        deq_valid;
    logic        deq_ready = 1'b0;
    logic [7:0]  deq_rank;
    logic [7:0]  deq_meta;
    logic [3:0]  occupancy;
    logic        pifo_insert;
    logic        pifo_remove;
    logic [7:0]  pifo_rank_in;
    logic [7:0]  pifo_meta_in;
    logic [7:0]  pifo_rank_out;
    logic [7:0]  pifo_meta_out;
    logic        pifo_valid_out;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pifo_sched_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .enq_valid      (enq_valid),
        .enq_ready      (enq_ready),
        .enq_rank       (enq_rank),
        .enq_meta       (enq_meta),
        .deq_valid      (deq_valid),
        .deq_ready      (deq_ready),
        .deq_rank       (deq_rank),
        .deq_meta       (deq_meta),
        .occupancy      (occupancy),
        .pifo_insert    (pifo_insert),
        .pifo_remove    (pifo_remove),
        .pifo_rank_in   (pifo_rank_in),
        .pifo_meta_in   (pifo_meta_in),
        .pifo_rank_out  (pifo_rank_out),
        .pifo_meta_out  (pifo_meta_out),
        .pifo_valid_out (pifo_valid_out)
    );

    // Behavioural PIFO: eight slots, head is the lowest rank (lowest slot on ties)
    logic [7:0] m_rank [8];
    logic [7:0] m_meta [8];
    logic [7:0] m_vld;
    int         m_free;
    int         m_min;
    logic       m_found;

    always_comb begin
        m_free  = 0;
        m_min   = 0;
        m_found = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            if (!m_vld[i]) m_free = i;
        end
        for (int i = 0; i < 8; i++) begin
            if (m_vld[i] && (!m_found || m_rank[i] < m_rank[m_min])) begin
                m_min   = i;
                m_found = 1'b1;
            end
        end
    end

    assign pifo_valid_out = m_found;
    assign pifo_rank_out  = m_found ? m_rank[m_min] : 8'h00;
    assign pifo_meta_out  = m_found ? m_meta[m_min] : 8'h00;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_vld <= '0;
        end else begin
            if (pifo_insert) begin
                m_rank[m_free] <= pifo_rank_in;
                m_meta[m_free] <= pifo_meta_in;
                m_vld[m_free]  <= 1'b1;
            end
            if (pifo_remove) m_vld[m_min] <= 1'b0;
        end
    end

    task automatic do_reset();
        rst       = 1'b1;
        enq_valid = '0;
        deq_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Called at a negedge in IDLE with no competing requests; returns at IDLE
    task automatic do_insert(input int p, input logic [7:0] r, input logic [7:0] m);
        enq_valid       = '0;
        enq_valid[p]    = 1'b1;
        enq_rank[p*8 +: 8] = r;
        enq_meta[p*8 +: 8] = m;
        @(negedge clk);
        enq_valid = '0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        enq_valid = 4'hF;
        @(negedge clk);
        #1;
        checks++; if (enq_ready !== 4'h0) begin failures++; $display("FAIL reset_enq_ready: got %b expected 0000", enq_ready); end
        checks++; if (occupancy !== 4'd0) begin failures++; $display("FAIL reset_occupancy: got %0d expected 0", occupancy); end
        checks++; if (deq_valid !== 1'b0) begin failures++; $display("FAIL reset_deq_valid: got %b expected 0", deq_valid); end
        checks++; if (pifo_insert !== 1'b0 || pifo_remove !== 1'b0) begin failures++; $display("FAIL reset_pifo_ops: got ins=%b rem=%b expected 0/0", pifo_insert, pifo_remove); end
        enq_valid = '0;
    endtask

    task automatic test_single_insert();
        do_reset();
        enq_valid        = 4'b0100;
        enq_rank[23:16]  = 8'd5;
        enq_meta[23:16]  = 8'hA2;
        #1;
        checks++; if (enq_ready !== 4'b0100) begin failures++; $display("FAIL single_grant: got %b expected 0100", enq_ready); end
        checks++; if (pifo_insert !== 1'b1) begin failures++; $display("FAIL single_insert: got %b expected 1", pifo_insert); end
        checks++; if (pifo_rank_in !== 8'd5 || pifo_meta_in !== 8'hA2) begin failures++; $display("FAIL single_fields: got %0h/%0h expected 5/a2", pifo_rank_in, pifo_meta_in); end
        @(negedge clk);
        enq_valid = '0;
        #1;
        checks++; if (occupancy !== 4'd1) begin failures++; $display("FAIL single_occ: got %0d expected 1", occupancy); end
        checks++; if (deq_valid !== 1'b0) begin failures++; $display("FAIL single_settle1_deq: got %b expected 0", deq_valid); end
        @(negedge clk);
        #1;
        checks++; if (deq_valid !== 1'b0) begin failures++; $display("FAIL single_settle2_deq: got %b expected 0", deq_valid); end
        @(negedge clk);
        #1;
        checks++; if (deq_valid !== 1'b1 || deq_rank !== 8'd5 || deq_meta !== 8'hA2) begin failures++; $display("FAIL single_head: got v=%b r=%0d m=%0h expected 1/5/a2", deq_valid, deq_rank, deq_meta); end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp;
        do_reset();
        enq_rank  = 32'h0D0C0B0A;
        enq_meta  = 32'h44332211;
        enq_valid = 4'hF;
        for (int k = 0; k < 5; k++) begin
            exp = '0;
            exp[k % 4] = 1'b1;
            #1;
            checks++; if (enq_ready !== exp) begin failures++; $display("FAIL rr_grant%0d: got %b expected %b", k, enq_ready, exp); end
            @(negedge clk);
            #1;
            checks++; if (enq_ready !== 4'h0) begin failures++; $display("FAIL rr_settle%0d: got %b expected 0000", k, enq_ready); end
            @(negedge clk);
            @(negedge clk);
        end
        #1;
        checks++; if (occupancy !== 4'd5) begin failures++; $display("FAIL rr_occ: got %0d expected 5", occupancy); end
        enq_valid = '0;
    endtask

    task automatic test_fill();
        do_reset();
        enq_valid = 4'b0001;
        for (int k = 0; k < 8; k++) begin
            enq_rank[7:0] = 8'(20 + k);
            #1;
            checks++; if (enq_ready !== 4'b0001) begin failures++; $display("FAIL fill_grant%0d: got %b expected 0001", k, enq_ready); end
            repeat (3) @(negedge clk);
        end
        #1;
        checks++; if (occupancy !== 4'd8) begin failures++; $display("FAIL fill_occ: got %0d expected 8", occupancy); end
        checks++; if (enq_ready !== 4'h0) begin failures++; $display("FAIL fill_full_ready: got %b expected 0000", enq_ready); end
        checks++; if (deq_valid !== 1'b1 || deq_rank !== 8'd20) begin failures++; $display("FAIL fill_head: got v=%b r=%0d expected 1/20", deq_valid, deq_rank); end
        @(negedge clk);
        #1;
        checks++; if (enq_ready !== 4'h0 || pifo_insert !== 1'b0) begin failures++; $display("FAIL fill_full_hold: got %b ins=%b expected 0000/0", enq_ready, pifo_insert); end
        deq_ready = 1'b1;
        #1;
        checks++; if (pifo_remove !== 1'b1) begin failures++; $display("FAIL fill_remove: got %b expected 1", pifo_remove); end
        @(negedge clk);
        deq_ready = 1'b0;
        #1;
        checks++; if (occupancy !== 4'd7) begin failures++; $display("FAIL fill_occ_after_deq: got %0d expected 7", occupancy); end
        repeat (2) @(negedge clk);
        #1;
        checks++; if (enq_ready !== 4'b0001) begin failures++; $display("FAIL fill_regrant: got %b expected 0001", enq_ready); end
        enq_valid = '0;
    endtask

    task automatic test_contention();
        do_reset();
        do_insert(1, 8'd40, 8'h01);
        do_insert(1, 8'd41, 8'h02);
        do_insert(1, 8'd42, 8'h03);
        enq_valid = 4'b0001;
        enq_rank[7:0] = 8'd50;
        deq_ready = 1'b1;
        #1;
        checks++; if (pifo_remove !== 1'b1 || pifo_insert !== 1'b0) begin failures++; $display("FAIL cont_ops: got rem=%b ins=%b expected 1/0", pifo_remove, pifo_insert); end
        checks++; if (enq_ready !== 4'h0 || pifo_rank_in !== 8'd0) begin failures++; $display("FAIL cont_enq_blocked: got %b rank_in=%0d expected 0000/0", enq_ready, pifo_rank_in); end
        @(negedge clk);
        deq_ready = 1'b0;
        #1;
        checks++; if (occupancy !== 4'd2) begin failures++; $display("FAIL cont_occ: got %0d expected 2", occupancy); end
        repeat (2) @(negedge clk);
        #1;
        checks++; if (enq_ready !== 4'b0001 || pifo_rank_in !== 8'd50) begin failures++; $display("FAIL cont_late_grant: got %b rank_in=%0d expected 0001/50", enq_ready, pifo_rank_in); end
        @(negedge clk);
        enq_valid = '0;
        #1;
        checks++; if (occupancy !== 4'd3) begin failures++; $display("FAIL cont_occ_after: got %0d expected 3", occupancy); end
    endtask

    task automatic test_ordering();
        logic [7:0] exp_r [3];
        exp_r[0] = 8'd3;
        exp_r[1] = 8'd7;
        exp_r[2] = 8'd9;
        do_reset();
        do_insert(3, 8'd9, 8'h39);
        do_insert(3, 8'd3, 8'h33);
        do_insert(3, 8'd7, 8'h37);
        deq_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if (deq_valid !== 1'b1 || pifo_remove !== 1'b1 || deq_rank !== exp_r[k] || deq_meta !== (exp_r[k] + 8'h30)) begin
                failures++;
                $display("FAIL order_deq%0d: got v=%b rem=%b r=%0d m=%0h expected 1/1/%0d/%0h", k, deq_valid, pifo_remove, deq_rank, deq_meta, exp_r[k], exp_r[k] + 8'h30);
            end
            repeat (3) @(negedge clk);
        end
        #1;
        checks++; if (occupancy !== 4'd0 || deq_valid !== 1'b0) begin failures++; $display("FAIL order_empty: got occ=%0d v=%b expected 0/0", occupancy, deq_valid); end
        deq_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        do_reset();
        do_insert(0, 8'd1, 8'h00);
        enq_valid       = 4'b0100;
        enq_rank[23:16] = 8'd6;
        @(negedge clk);
        enq_valid = 4'hF;
        #2;
        rst = 1'b1;
        #1;
        checks++; if (occupancy !== 4'd0) begin failures++; $display("FAIL arst_occ: got %0d expected 0", occupancy); end
        checks++; if (enq_ready !== 4'h0 || deq_valid !== 1'b0 || pifo_insert !== 1'b0 || pifo_remove !== 1'b0 || pifo_rank_in !== 8'd0) begin
            failures++;
            $display("FAIL arst_outputs: got rdy=%b dv=%b ins=%b rem=%b rin=%0d expected all 0", enq_ready, deq_valid, pifo_insert, pifo_remove, pifo_rank_in);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (enq_ready !== 4'b0001) begin failures++; $display("FAIL arst_resume_port0: got %b expected 0001", enq_ready); end
        checks++; if (deq_valid !== 1'b0 || occupancy !== 4'd0) begin failures++; $display("FAIL arst_empty: got v=%b occ=%0d expected 0/0", deq_valid, occupancy); end
        enq_valid = '0;
    endtask

    initial begin
        test_reset();
        test_single_insert();
        test_round_robin();
        test_fill();
        test_contention();
        test_ordering();
        test_async_reset();
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
